seq_detector: RTL and testbench

// - Serial pattern detector directly downstream of the sequence generator; consumes its MSB-first bit stream (seq[15]).
// - Mealy-style FSM recognises the 5-bit pattern 1-0-1-1-0 (first bit received first).
// - Emits a registered one-cycle detect pulse plus an LED-visible stretched flag.
// - Optional saturating match counter.

---
 rtl/seq_detector.sv | 102 ++++++++++
 tb/tb_seq_detector.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector.sv
// Serial detector for the MSB-first pattern 1-0-1-1-0 with a registered match pulse and a stretched LED flag.
// Define SEQ_DET_CNT_EN to add the clr input and the saturating match_cnt output.
module seq_detector #(
  parameter int OVERLAP  = 1,
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
`ifdef SEQ_DET_CNT_EN
  input  logic             clr,
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             det,
  output logic             det_led,
  output logic [2:0]       state
);

  // din is consumed only on edges where din_vld=1; there is no backpressure,
  // so one qualified bit is accepted every cycle it is offered.

  localparam int HOLD_W = 16 + 0 * CNT_W;
  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYC);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              match;
  logic [HOLD_W-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    match   = 1'b0;
    case (state_q)
      S0: if (din_vld) state_d = din ? S1 : S0;
      S1: if (din_vld) state_d = din ? S1 : S2;
      S2: if (din_vld) state_d = din ? S3 : S0;
      S3: if (din_vld) state_d = din ? S4 : S2;
      S4: begin
        if (din_vld) begin
          if (din) begin
            state_d = S1;
          end else begin
            match   = 1'b1;
            // The trailing "10" of a match is itself a valid prefix.
            state_d = (OVERLAP != 0) ? S2 : S0;
          end
        end
      end
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      det    <= 1'b0;
      hold_q <= '0;
    end else begin
      det <= match;
      if (match) begin
        hold_q <= HOLD_LD;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - HOLD_W'(1);
      end
    end
  end

  assign det_led = (hold_q != '0);
  assign state   = state_q;

`ifdef SEQ_DET_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (clr) begin
      match_cnt <= '0;
    end else if (match && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: an overlapping and a non-overlapping instance share one input stream and
// are checked every cycle against a suffix-matching reference model, plus directed scenarios.
module tb_seq_detector;

  localparam int HOLD_A = 4;
  localparam int HOLD_B = 3;
  localparam logic [4:0] PAT = 5'b10110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       din_vld;
  logic       clr;
  logic       det_a, led_a, det_b, led_b;
  logic [2:0] st_a, st_b;
`ifdef SEQ_DET_CNT_EN
  logic [7:0] mc_a;
  logic [1:0] mc_b;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: last five accepted bits (newest in bit 0) and how many are meaningful.
  logic [4:0] h_a, h_b;
  int         len_a, len_b, last_a, last_b, mcm_a, mcm_b;
  bit         m_a, m_b;

  always #5 clk = ~clk;

  seq_detector #(.OVERLAP(1), .HOLD_CYC(HOLD_A), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
`ifdef SEQ_DET_CNT_EN
    .clr(clr), .match_cnt(mc_a),
`endif
    .det(det_a), .det_led(led_a), .state(st_a)
  );

  seq_detector #(.OVERLAP(0), .HOLD_CYC(HOLD_B), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
`ifdef SEQ_DET_CNT_EN
    .clr(clr), .match_cnt(mc_b),
`endif
    .det(det_b), .det_led(led_b), .state(st_b)
  );

  // Longest proper suffix of the accepted history that is a prefix of the pattern.
  function automatic int suffix_len(logic [4:0] h, int len);
    int best = 0;
    for (int k = 1; k <= 4; k++) begin
      bit ok = (len >= k);
      for (int i = 0; i < k; i++) begin
        if (h[k-1-i] != PAT[4-i]) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  task automatic model_step(input bit b, input bit v, input bit c, input bit r, input bit ovl,
                            input int cmax, inout logic [4:0] h, inout int len, inout int last,
                            inout int mc, output bit m);
    m = 1'b0;
    if (r) begin
      h = '0; len = 0; last = -100000; mc = 0;
    end else begin
      if (v) begin
        h = {h[3:0], b};
        if (len < 5) len++;
        m = (len == 5) && (h == PAT);
        if (m) begin
          last = cyc;
          if (!ovl) len = 0;
        end
      end
      if (c) mc = 0;
      else if (m && mc < cmax) mc++;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit b, input bit v, input bit c = 1'b0, input bit r = 1'b0);
    din = b; din_vld = v; clr = c; rst_n = !r;
    cyc++;
    model_step(b, v, c, r, 1'b1, 255, h_a, len_a, last_a, mcm_a, m_a);
    model_step(b, v, c, r, 1'b0, 3,   h_b, len_b, last_b, mcm_b, m_b);
    @(posedge clk);
    #1;
    chk("det_a",   16'(det_a), 16'(m_a));
    chk("led_a",   16'(led_a), 16'((cyc - last_a) < HOLD_A));
    chk("state_a", 16'(st_a),  16'(suffix_len(h_a, len_a)));
    chk("det_b",   16'(det_b), 16'(m_b));
    chk("led_b",   16'(led_b), 16'((cyc - last_b) < HOLD_B));
    chk("state_b", 16'(st_b),  16'(suffix_len(h_b, len_b)));
`ifdef SEQ_DET_CNT_EN
    chk("cnt_a", 16'(mc_a), 16'(mcm_a));
    chk("cnt_b", 16'(mc_b), 16'(mcm_b));
`endif
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) step(bits[n-1-i], 1'b1);
  endtask

  initial begin
    logic [15:0] word;
    logic [7:0]  ob;
    int          nd, led_n_a, led_n_b;
    logic [2:0]  s;

    rst_n = 1'b0; din = 1'b0; din_vld = 1'b0; clr = 1'b0;

    // Reset held for three edges with random inputs.
    for (int i = 0; i < 3; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    chk("rst_state", 16'(st_a), 16'd0);
    chk("rst_det",   16'(det_a), 16'd0);
    chk("rst_led",   16'(led_a), 16'd0);
`ifdef SEQ_DET_CNT_EN
    chk("rst_cnt",   16'(mc_a), 16'd0);
`endif

    // Upstream generator stream, four periods.
    word = 16'h0D95;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) begin
        step(word[15-i], 1'b1);
        chk("up_det_a", 16'(det_a), 16'(i == 9));
        chk("up_det_b", 16'(det_b), 16'(i == 9));
      end
    end
`ifdef SEQ_DET_CNT_EN
    chk("up_cnt_a", 16'(mc_a), 16'd4);
    chk("up_cnt_sat_b", 16'(mc_b), 16'd3);
`endif

    // Overlapping matches.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ob = 8'hB6;
    for (int i = 0; i < 8; i++) begin
      step(ob[7-i], 1'b1);
      chk("ov_det_a", 16'(det_a), 16'(i == 4 || i == 7));
      chk("ov_det_b", 16'(det_b), 16'(i == 4));
    end

    // Pattern with three invalid cycles after each bit.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      step(PAT[4-i], 1'b1);
      nd += int'(det_a);
      s = st_a;
      for (int g = 0; g < 3; g++) begin
        step(1'(g % 2 == 0 ? !PAT[4-i] : PAT[4-i]), 1'b0);
        chk("gap_state", 16'(st_a), 16'(s));
        chk("gap_det", 16'(det_a), 16'd0);
      end
    end
    chk("gap_ndet", 16'(nd), 16'd1);

    // Single match stretch.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    led_n_a = 0;
    for (int i = 0; i < 5; i++) begin
      step(PAT[4-i], 1'b1);
      led_n_a += int'(led_a);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      led_n_a += int'(led_a);
    end
    chk("stretch_1", 16'(led_n_a), 16'(HOLD_A));

    // Retrigger: second overlapping match three cycles after the first.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    led_n_a = 0; led_n_b = 0;
    for (int i = 0; i < 8; i++) begin
      step(ob[7-i], 1'b1);
      led_n_a += int'(led_a);
      led_n_b += int'(led_b);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0);
      led_n_a += int'(led_a);
      led_n_b += int'(led_b);
    end
    chk("stretch_re_a", 16'(led_n_a), 16'(3 + HOLD_A));
    chk("stretch_re_b", 16'(led_n_b), 16'(HOLD_B));

    // Reset in the middle of a pattern.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(16'b1011, 4);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("midrst_det_a", 16'(det_a), 16'd0);
    chk("midrst_st_a",  16'(st_a),  16'd0);
    chk("midrst_det_b", 16'(det_b), 16'd0);

`ifdef SEQ_DET_CNT_EN
    // clr coincident with a match wins.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    feed(16'b10110, 5);
    chk("clr_pre", 16'(mc_a), 16'd1);
    feed(16'b1011, 4);
    step(1'b0, 1'b1, 1'b1);
    chk("clr_det",   16'(det_a), 16'd1);
    chk("clr_cnt_a", 16'(mc_a),  16'd0);
    chk("clr_cnt_b", 16'(mc_b),  16'd0);
`endif

    // Random traffic with occasional clr and reset.
    for (int n = 0; n < 3000; n++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
